// File: rtl/oppm_pkg.sv
// Shared types and elaboration helpers for the OPPM frame transmitter.
package oppm_pkg;

    typedef enum logic [2:0] {StIdle, StPream, StSync, StData, StGap} oppm_state_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Bits needed to hold 0..x, never less than one.
    function automatic int unsigned clog2w(input int unsigned x);
        return (x == 0) ? 1 : $clog2(x + 1);
    endfunction

endpackage

// File: rtl/oppm_symbol_timer.sv
// Symbol-period tick counter split into slot index and tick-in-slot.
module oppm_symbol_timer
    import oppm_pkg::*;
#(
    parameter int unsigned N_MOD = 2,
    parameter int unsigned L     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    output logic [N_MOD-1:0]           slot_o,
    output logic [clog2w(L-1)-1:0]     sub_o,
    output logic                       sym_end_o
);

    localparam int unsigned SUB_W = clog2w(L - 1);

    logic [N_MOD-1:0] slot_q, slot_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             sub_end;

    always_comb begin
        sub_end = (sub_q == SUB_W'(L - 1));
        slot_d  = slot_q;
        sub_d   = sub_q;
        if (clear_i) begin
            slot_d = '0;
            sub_d  = '0;
        end else if (sub_end) begin
            slot_d = slot_q + 1'b1;
            sub_d  = '0;
        end else begin
            sub_d  = sub_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            sub_q  <= '0;
        end else begin
            slot_q <= slot_d;
            sub_q  <= sub_d;
        end
    end

    assign slot_o    = slot_q;
    assign sub_o     = sub_q;
    assign sym_end_o = sub_end && (&slot_q);

endmodule

// File: rtl/oppm_frame_tx.sv
// OPPM frame transmitter: preamble, sync, padded data symbols and guard gap per packet.
module oppm_frame_tx
    import oppm_pkg::*;
#(
    parameter int unsigned PULSE_CT  = 2,
    parameter int unsigned N_MOD     = 2,
    parameter int unsigned L         = 4,
    parameter int unsigned N_PKT     = 8,
    parameter int unsigned PRE_CT    = 2,
    parameter int unsigned SYNC_SYM  = 2 ** N_MOD - 1,
    parameter int unsigned GAP_CT    = 1,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_PKT-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             pulse_o
);

    localparam int unsigned D_SYM   = ceil_div(N_PKT, N_MOD);
    localparam int unsigned PAD_W   = D_SYM * N_MOD;
    localparam int unsigned MAX_CNT = (PRE_CT > D_SYM) ? ((PRE_CT > GAP_CT) ? PRE_CT : GAP_CT)
                                                       : ((D_SYM > GAP_CT) ? D_SYM : GAP_CT);
    localparam int unsigned SYM_W   = clog2w(MAX_CNT);
    localparam int unsigned SUB_W   = clog2w(L - 1);

    localparam logic [SYM_W-1:0] PRE_LAST  = SYM_W'((PRE_CT > 0) ? PRE_CT - 1 : 0);
    localparam logic [SYM_W-1:0] DATA_LAST = SYM_W'(D_SYM - 1);
    localparam logic [SYM_W-1:0] GAP_LAST  = SYM_W'((GAP_CT > 0) ? GAP_CT - 1 : 0);
    localparam oppm_state_e      FIRST_ST  = (PRE_CT > 0) ? StPream : StSync;
    localparam bit               HAS_GAP   = (GAP_CT > 0);
    localparam bit               MSB_F     = (MSB_FIRST != 0);

    if (PULSE_CT < 1 || PULSE_CT > L) begin : gen_bad_pulse_ct
        $error("oppm_frame_tx: PULSE_CT must lie in 1..L");
    end
    if (SYNC_SYM >= 2 ** N_MOD) begin : gen_bad_sync_sym
        $error("oppm_frame_tx: SYNC_SYM does not fit in N_MOD bits");
    end

    oppm_state_e      state_q, state_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic [PAD_W-1:0] shreg_q, shreg_d;
    logic             pulse_q, pulse_d;

    logic [N_MOD-1:0] slot, slot_n, sym_val;
    logic [SUB_W-1:0] sub, sub_n;
    logic             sym_end, last_sym, state_last, frame_end, accept, emit;

    oppm_symbol_timer #(
        .N_MOD (N_MOD),
        .L     (L)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == StIdle),
        .slot_o    (slot),
        .sub_o     (sub),
        .sym_end_o (sym_end)
    );

    always_comb begin
        last_sym = 1'b0;
        case (state_q)
            StPream: last_sym = (sym_q == PRE_LAST);
            StSync:  last_sym = 1'b1;
            StData:  last_sym = (sym_q == DATA_LAST);
            StGap:   last_sym = (sym_q == GAP_LAST);
            default: last_sym = 1'b0;
        endcase
        state_last = sym_end && last_sym;
        frame_end  = state_last && ((state_q == StData && !HAS_GAP) || state_q == StGap);
        ready_o    = (state_q == StIdle) || frame_end;
        accept     = valid_i && ready_o;

        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = FIRST_ST;
            StPream: if (state_last) state_d = StSync;
            StSync:  if (state_last) state_d = StData;
            StData: begin
                if (state_last) begin
                    if (HAS_GAP) state_d = StGap;
                    else         state_d = accept ? FIRST_ST : StIdle;
                end
            end
            StGap:   if (state_last) state_d = accept ? FIRST_ST : StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) sym_d = '0;
        else if (sym_end)       sym_d = sym_q + 1'b1;
        else                    sym_d = sym_q;

        shreg_d = shreg_q;
        if (accept) begin
            shreg_d = MSB_F ? (PAD_W'(data_i) << (PAD_W - N_PKT)) : PAD_W'(data_i);
        end else if (state_q == StData && sym_end) begin
            shreg_d = MSB_F ? (shreg_q << N_MOD) : (shreg_q >> N_MOD);
        end
    end

    // The pulse flop is loaded with the value for the tick that starts after this edge,
    // so a preamble pulse appears in the very first cycle after accept.
    always_comb begin
        slot_n = slot;
        sub_n  = sub;
        if (state_q == StIdle || sym_end) begin
            slot_n = '0;
            sub_n  = '0;
        end else if (sub == SUB_W'(L - 1)) begin
            slot_n = slot + 1'b1;
            sub_n  = '0;
        end else begin
            sub_n  = sub + 1'b1;
        end

        emit    = 1'b0;
        sym_val = '0;
        case (state_d)
            StPream: emit = 1'b1;
            StSync: begin
                emit    = 1'b1;
                sym_val = N_MOD'(SYNC_SYM);
            end
            StData: begin
                emit    = 1'b1;
                sym_val = MSB_F ? shreg_d[PAD_W-1 -: N_MOD] : shreg_d[N_MOD-1:0];
            end
            default: emit = 1'b0;
        endcase
        pulse_d = emit && (slot_n == sym_val) && (32'(sub_n) < PULSE_CT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sym_q   <= '0;
            shreg_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            shreg_q <= shreg_d;
            pulse_q <= pulse_d;
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = frame_end;
    assign pulse_o      = pulse_q;

endmodule

// File: tb/tb_oppm_frame_tx.sv
// Directed bench for oppm_frame_tx across four parameter sets sharing one clock and reset.
module tb_oppm_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] valid = '0;
    logic [7:0] data_v [4];
    logic [3:0] pulse_v, ready_v, busy_v, done_v;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // 0: defaults, 1: LSB first, 2: 7-bit packet, 3: no preamble
    oppm_frame_tx u_def (
        .clk(clk), .rst_n(rst_n), .data_i(data_v[0]), .valid_i(valid[0]),
        .ready_o(ready_v[0]), .busy_o(busy_v[0]), .frame_done_o(done_v[0]), .pulse_o(pulse_v[0])
    );
    oppm_frame_tx #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .data_i(data_v[1]), .valid_i(valid[1]),
        .ready_o(ready_v[1]), .busy_o(busy_v[1]), .frame_done_o(done_v[1]), .pulse_o(pulse_v[1])
    );
    oppm_frame_tx #(.N_PKT(7)) u_p7 (
        .clk(clk), .rst_n(rst_n), .data_i(data_v[2][6:0]), .valid_i(valid[2]),
        .ready_o(ready_v[2]), .busy_o(busy_v[2]), .frame_done_o(done_v[2]), .pulse_o(pulse_v[2])
    );
    oppm_frame_tx #(.PRE_CT(0)) u_pre0 (
        .clk(clk), .rst_n(rst_n), .data_i(data_v[3]), .valid_i(valid[3]),
        .ready_o(ready_v[3]), .busy_o(busy_v[3]), .frame_done_o(done_v[3]), .pulse_o(pulse_v[3])
    );

    // Two-tick pulses starting at each listed frame tick; negative entries are unused.
    function automatic logic [127:0] pat(input int a, b, c, d, e, f, g);
        int r[7];
        logic [127:0] x;
        r = '{a, b, c, d, e, f, g};
        x = '0;
        foreach (r[i]) begin
            if (r[i] >= 0) begin
                x[r[i]]     = 1'b1;
                x[r[i] + 1] = 1'b1;
            end
        end
        return x;
    endfunction

    function automatic logic [127:0] mask(input int len);
        logic [127:0] x;
        x = '0;
        for (int i = 0; i < len; i++) x[i] = 1'b1;
        return x;
    endfunction

    function automatic logic [127:0] one(input int i);
        logic [127:0] x;
        x = '0;
        x[i] = 1'b1;
        return x;
    endfunction

    // Called at a negedge while idle; returns at the negedge inside frame tick 0.
    task automatic start(input int sel, input logic [7:0] d);
        valid[sel]  = 1'b1;
        data_v[sel] = d;
        @(negedge clk);
    endtask

    // Records len ticks starting at the current negedge (frame tick 0).
    task automatic capture(input int sel, input int len, input int chg_tick,
                           input logic [7:0] chg_data, input int drop_tick,
                           output logic [127:0] p, output logic [127:0] r,
                           output logic [127:0] d, output logic [127:0] b);
        p = '0; r = '0; d = '0; b = '0;
        for (int t = 0; t < len; t++) begin
            p[t] = pulse_v[sel];
            r[t] = ready_v[sel];
            d[t] = done_v[sel];
            b[t] = busy_v[sel];
            if (t == chg_tick)  data_v[sel] = chg_data;
            if (t == drop_tick) valid[sel] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (ready_v !== 4'hF) begin errors++; $display("FAIL reset_ready got %b want 1111", ready_v); end
        checks++; if (busy_v !== 4'h0) begin errors++; $display("FAIL reset_busy got %b want 0000", busy_v); end
        checks++; if (done_v !== 4'h0) begin errors++; $display("FAIL reset_done got %b want 0000", done_v); end
        checks++; if (pulse_v !== 4'h0) begin errors++; $display("FAIL reset_pulse got %b want 0000", pulse_v); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (pulse_v !== 4'h0 || busy_v !== 4'h0 || ready_v !== 4'hF) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_frame(input string name, input int sel, input int len,
                              input logic [7:0] d, input logic [127:0] exp_p);
        logic [127:0] p, r, dn, b;
        checks++; if (ready_v[sel] !== 1'b1) begin errors++; $display("FAIL %s_ready_idle got %b want 1", name, ready_v[sel]); end
        start(sel, d);
        capture(sel, len, -1, 8'h00, 0, p, r, dn, b);
        checks++; if (p !== exp_p) begin errors++; $display("FAIL %s_pulse got %h want %h", name, p, exp_p); end
        checks++; if (dn !== one(len - 1)) begin errors++; $display("FAIL %s_done got %h want %h", name, dn, one(len - 1)); end
        checks++; if (r !== one(len - 1)) begin errors++; $display("FAIL %s_ready got %h want %h", name, r, one(len - 1)); end
        checks++; if (b !== mask(len)) begin errors++; $display("FAIL %s_busy got %h want %h", name, b, mask(len)); end
        checks++; if (busy_v[sel] !== 1'b0 || pulse_v[sel] !== 1'b0) begin
            errors++; $display("FAIL %s_after got busy %b pulse %b want 0 0", name, busy_v[sel], pulse_v[sel]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] p1, r1, d1, b1, p2, r2, d2, b2;
        start(0, 8'hB4);
        // valid stays high; data changes mid-frame and becomes the second packet
        capture(0, 128, 50, 8'h1B, -1, p1, r1, d1, b1);
        capture(0, 128, -1, 8'h00, 0, p2, r2, d2, b2);
        checks++; if (p1 !== pat(0, 16, 44, 56, 76, 84, 96)) begin
            errors++; $display("FAIL b2b_pulse1 got %h want %h", p1, pat(0, 16, 44, 56, 76, 84, 96));
        end
        checks++; if (r1 !== one(127)) begin errors++; $display("FAIL b2b_ready1 got %h want %h", r1, one(127)); end
        checks++; if (b1 !== mask(128) || b2 !== mask(128)) begin
            errors++; $display("FAIL b2b_busy got %h %h want all ones", b1, b2);
        end
        checks++; if (p2 !== pat(0, 16, 44, 48, 68, 88, 108)) begin
            errors++; $display("FAIL b2b_pulse2 got %h want %h", p2, pat(0, 16, 44, 48, 68, 88, 108));
        end
        checks++; if (d2 !== one(127)) begin errors++; $display("FAIL b2b_done2 got %h want %h", d2, one(127)); end
        checks++; if (busy_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
            errors++; $display("FAIL b2b_after got busy %b ready %b want 0 1", busy_v[0], ready_v[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] p, r, d, b;
        start(0, 8'hB4);
        valid[0] = 1'b0;
        // tick 56 carries a data pulse, so an asynchronous drop is observable
        repeat (56) @(negedge clk);
        checks++; if (pulse_v[0] !== 1'b1) begin errors++; $display("FAIL rst_pre_pulse got %b want 1", pulse_v[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (pulse_v[0] !== 1'b0) begin errors++; $display("FAIL rst_async_pulse got %b want 0", pulse_v[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            errors++; $display("FAIL rst_release got ready %b busy %b want 1 0", ready_v[0], busy_v[0]);
        end
        start(0, 8'hB4);
        capture(0, 128, -1, 8'h00, 0, p, r, d, b);
        checks++; if (p !== pat(0, 16, 44, 56, 76, 84, 96)) begin
            errors++; $display("FAIL rst_new_frame got %h want %h", p, pat(0, 16, 44, 56, 76, 84, 96));
        end
    endtask

    initial begin
        foreach (data_v[i]) data_v[i] = 8'h00;
        test_reset();
        test_idle();
        test_frame("msb", 0, 128, 8'hB4, pat(0, 16, 44, 56, 76, 84, 96));
        test_frame("lsb", 1, 128, 8'hB4, pat(0, 16, 44, 48, 68, 92, 104));
        test_frame("pad7", 2, 128, 8'h7F, pat(0, 16, 44, 60, 76, 92, 104));
        test_frame("pre0", 3, 96, 8'hB4, pat(12, 24, 44, 52, 64, -1, -1));
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
